sobel_frame_ctrl: RTL and testbench

- Frame-level sequencer for the Sobel datapath. Accepts a raster pixel stream, buffers two lines, and forms a 3x3 window around each interior pixel. Presents the window to the Sobel filter core, then realigns the filter's result with its pixel coordinates.
- Sits between the pixel source and the Sobel filter core. Provides start/busy/done frame control and runtime width/height configuration.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_line_buffer.sv | 28 ++
 rtl/sobel_frame_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel frame controller: pixel, 3x3 window and FSM states.
package sobel_pkg;
  localparam int WIN_PIX_W = 8;
  localparam int WIN_SIZE  = 3;

  typedef logic [WIN_PIX_W-1:0] pix_t;
  // win[row][col]; as a 72-bit vector [0][0] lands in bits [7:0]
  typedef pix_t [WIN_SIZE-1:0][WIN_SIZE-1:0] win_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store with a shared column address.
// Reads are combinational so the old column is seen before the write lands.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] col,
  input  pix_t          din,
  output pix_t          line1,
  output pix_t          line2
);
  pix_t mem1 [MAX_WIDTH];
  pix_t mem2 [MAX_WIDTH];

  assign line1 = mem1[col];
  assign line2 = mem2[col];

  always_ff @(posedge clk) begin
    if (we) begin
      mem1[col] <= din;
      mem2[col] <= mem1[col];
    end
  end
endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding 3x3 windows to the Sobel core and realigning results.
// Optional SOBEL_BORDER_ZERO_EN also emits zero-valued border results.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int CW         = 10,
  parameter int FILTER_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_height,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  input  logic [7:0]    s_pixel,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [71:0]   win_pixels,
  output logic          win_valid,
  input  logic [7:0]    edge_in,
  output logic [7:0]    m_edge,
  output logic [CW-1:0] m_x,
  output logic [CW-1:0] m_y,
  output logic          m_valid
);
  localparam int DL = FILTER_LAT + 1;

  state_t        state;
  logic [CW-1:0] w_cfg, h_cfg, x, y;
  pix_t          line1, line2;
  win_t          win;
  logic          xfer, last_x, last_y, fire, cfg_ok;
  logic          room, flush;
  logic [DL-1:0] dv;
  logic [CW-1:0] dx [DL];
  logic [CW-1:0] dy [DL];

  assign cfg_ok = cfg_width >= CW'(3) && cfg_width <= CW'(MAX_WIDTH) &&
                  cfg_height >= CW'(3) && cfg_height <= CW'(MAX_HEIGHT);
  assign last_x = x == w_cfg - CW'(1);
  assign last_y = y == h_cfg - CW'(1);
  assign s_ready = state == RUN && room;
  assign xfer = s_valid && s_ready;
  assign fire = xfer && x >= CW'(2) && y >= CW'(2);
  assign win_pixels = win;

`ifdef SOBEL_BORDER_ZERO_EN
  logic [DL-1:0] dbv;
  logic [CW-1:0] dbx [DL];
  logic [CW-1:0] dby [DL];
  logic [CW-1:0] fx [2];
  logic [CW-1:0] fy [2];
  logic [1:0]    fcnt;
  logic          border, push, pop, widx;
  int unsigned   occ;

  // every in-flight border result may still need a FIFO slot
  always_comb begin
    occ = 32'(fcnt);
    for (int k = 0; k < DL; k++) occ += 32'(dbv[k]);
  end

  assign room   = occ < 2;
  assign flush  = fcnt == 2'd0 && dbv == '0;
  assign border = xfer && (x == '0 || last_x || y == '0 || last_y);
  assign pop    = !dv[DL-1] && fcnt != 2'd0;
  assign push   = dbv[DL-1] && (dv[DL-1] || fcnt != 2'd0);
  assign widx   = fcnt == 2'd2 || (fcnt == 2'd1 && !pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt <= '0;
    else fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      fx[0] <= fx[1];
      fy[0] <= fy[1];
    end
    if (push) begin
      fx[widx] <= dbx[DL-1];
      fy[widx] <= dby[DL-1];
    end
  end
`else
  assign room  = 1'b1;
  assign flush = 1'b1;
`endif

  sobel_line_buffer #(
    .MAX_WIDTH(MAX_WIDTH),
    .CW       (CW)
  ) u_lb (
    .clk  (clk),
    .we   (xfer),
    .col  (x),
    .din  (s_pixel),
    .line1(line1),
    .line2(line2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      w_cfg   <= '0;
      h_cfg   <= '0;
      x       <= '0;
      y       <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            w_cfg <= cfg_width;
            h_cfg <= cfg_height;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        RUN: begin
          if (xfer && last_x) begin
            x <= '0;
            y <= y + CW'(1);
            if (last_y) state <= DRAIN;
          end else if (xfer) begin
            x <= x + CW'(1);
          end
        end
        DRAIN: begin
          if (dv == '0 && flush) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // column history restarts at every line so windows never straddle lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win <= '0;
    end else if (xfer) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        win[r][0] <= (x == '0) ? '0 : win[r][1];
        win[r][1] <= (x == '0) ? '0 : win[r][2];
      end
      win[0][2] <= line2;
      win[1][2] <= line1;
      win[2][2] <= s_pixel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
      dv        <= '0;
      for (int k = 0; k < DL; k++) begin
        dx[k] <= '0;
        dy[k] <= '0;
      end
`ifdef SOBEL_BORDER_ZERO_EN
      dbv <= '0;
      for (int k = 0; k < DL; k++) begin
        dbx[k] <= '0;
        dby[k] <= '0;
      end
`endif
    end else begin
      win_valid <= fire;
      dv[0]     <= fire;
      dx[0]     <= x - CW'(1);
      dy[0]     <= y - CW'(1);
      for (int k = 1; k < DL; k++) begin
        dv[k] <= dv[k-1];
        dx[k] <= dx[k-1];
        dy[k] <= dy[k-1];
      end
`ifdef SOBEL_BORDER_ZERO_EN
      dbv[0] <= border;
      dbx[0] <= x;
      dby[0] <= y;
      for (int k = 1; k < DL; k++) begin
        dbv[k] <= dbv[k-1];
        dbx[k] <= dbx[k-1];
        dby[k] <= dby[k-1];
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_edge  <= '0;
      m_x     <= '0;
      m_y     <= '0;
    end else begin
      m_valid <= dv[DL-1];
      if (dv[DL-1]) begin
        m_edge <= edge_in;
        m_x    <= dx[DL-1];
        m_y    <= dy[DL-1];
      end
`ifdef SOBEL_BORDER_ZERO_EN
      else if (pop) begin
        m_valid <= 1'b1;
        m_edge  <= '0;
        m_x     <= fx[0];
        m_y     <= fy[0];
      end else if (dbv[DL-1]) begin
        m_valid <= 1'b1;
        m_edge  <= '0;
        m_x     <= dbx[DL-1];
        m_y     <= dby[DL-1];
      end
`endif
    end
  end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a centre-echo filter stub.
module tb_sobel_frame_ctrl;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_height = '0;
  logic          start = 1'b0;
  logic          busy, done, cfg_err;
  logic [7:0]    s_pixel = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [71:0]   win_pixels;
  logic          win_valid;
  logic [7:0]    edge_in = '0;
  logic [7:0]    m_edge;
  logic [CW-1:0] m_x, m_y;
  logic          m_valid;

  typedef struct {
    int x;
    int y;
    int e;
    int c;
  } res_t;

  res_t q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc22 = 0;

  sobel_frame_ctrl #(
    .MAX_WIDTH (640),
    .MAX_HEIGHT(480),
    .CW        (CW),
    .FILTER_LAT(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .s_pixel   (s_pixel),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .win_pixels(win_pixels),
    .win_valid (win_valid),
    .edge_in   (edge_in),
    .m_edge    (m_edge),
    .m_x       (m_x),
    .m_y       (m_y),
    .m_valid   (m_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // filter stub: one-cycle echo of the window centre
  always @(posedge clk) edge_in <= win_pixels[39:32];

  always @(negedge clk) begin
    if (m_valid) q.push_back('{int'(m_x), int'(m_y), int'(m_edge), cyc});
    if (done) done_cnt = done_cnt + 1;
    if (cfg_err) err_cnt = err_cnt + 1;
  end

  task automatic run_frame(input int w, input int h, input bit gap,
                           input bit mid);
    int i, g;
    @(negedge clk);
    cfg_width = CW'(w);
    cfg_height = CW'(h);
    start = 1'b1;
    i = 0;
    g = 0;
    while (i < w * h && g < 4000) begin
      @(negedge clk);
      start = mid && i == 5;
      if (mid && i == 5) cfg_width = CW'(2);
      s_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      s_pixel = 8'(i);
      if (s_valid && s_ready) begin
        if (i == 2 * w + 2) acc22 = cyc;
        i++;
      end
      g++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    start = 1'b0;
    g = 0;
    while (busy && g < 60) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (busy !== 1'b0 || i != w * h) begin
      n_err++;
      $display("FAIL frame_end %0dx%0d: busy=%b pixels=%0d want busy=0 pixels=%0d",
               w, h, busy, i, w * h);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, cfg_err, s_ready, win_valid, m_valid} !== 6'b0 ||
        win_pixels !== 72'h0 || m_edge !== 8'h0 || m_x !== '0 || m_y !== '0) begin
      n_err++;
      $display("FAIL reset_state: ctl=%b win=%h m=%h,%0d,%0d want all zero",
               {busy, done, cfg_err, s_ready, win_valid, m_valid},
               win_pixels, m_edge, m_x, m_y);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_4x4();
    int   b, d;
    res_t r;
    int   ex[4] = '{1, 2, 1, 2};
    int   ey[4] = '{1, 1, 2, 2};
    int   ee[4] = '{5, 6, 9, 10};
    b = q.size();
    d = done_cnt;
    run_frame(4, 4, 1'b0, 1'b0);
    n_cmp++;
    if (q.size() - b !== 4) begin
      n_err++;
      $display("FAIL 4x4_count: got %0d want 4", q.size() - b);
    end
    for (int k = 0; k < 4; k++) begin
      if (b + k < q.size()) r = q[b+k];
      else r = '{-1, -1, -1, -1};
      n_cmp++;
      if (r.x !== ex[k] || r.y !== ey[k] || r.e !== ee[k]) begin
        n_err++;
        $display("FAIL 4x4_res%0d: got (%0d,%0d) e=%0d want (%0d,%0d) e=%0d",
                 k, r.x, r.y, r.e, ex[k], ey[k], ee[k]);
      end
    end
    if (b < q.size()) r = q[b];
    else r = '{-1, -1, -1, -1};
    n_cmp++;
    if (r.c - acc22 !== 3) begin
      n_err++;
      $display("FAIL 4x4_latency: got %0d want 3", r.c - acc22);
    end
    n_cmp++;
    if (done_cnt - d !== 1) begin
      n_err++;
      $display("FAIL 4x4_done: got %0d pulses want 1", done_cnt - d);
    end
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL 4x4_idle_ready: got %b want 0", s_ready);
    end
  endtask

  task automatic test_min_frame();
    int   b;
    res_t r;
    b = q.size();
    run_frame(3, 3, 1'b0, 1'b0);
    if (b < q.size()) r = q[b];
    else r = '{-1, -1, -1, -1};
    n_cmp++;
    if (q.size() - b !== 1 || r.x !== 1 || r.y !== 1 || r.e !== 4) begin
      n_err++;
      $display("FAIL 3x3_frame: got n=%0d (%0d,%0d) e=%0d want n=1 (1,1) e=4",
               q.size() - b, r.x, r.y, r.e);
    end
  endtask

  task automatic test_cfg_err();
    int bad_w[2] = '{2, 4};
    int bad_h[2] = '{4, 481};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_width = CW'(bad_w[k]);
      cfg_height = CW'(bad_h[k]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_err_pulse%0d: err=%b busy=%b ready=%b want 1,0,0",
                 k, cfg_err, busy, s_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_err_clear%0d: err=%b busy=%b ready=%b want 0,0,0",
                 k, cfg_err, busy, s_ready);
      end
    end
  endtask

  task automatic test_gaps();
    int   b;
    res_t r;
    int   ee[3] = '{6, 7, 8};
    for (int p = 0; p < 2; p++) begin
      b = q.size();
      run_frame(5, 3, p == 1, 1'b0);
      n_cmp++;
      if (q.size() - b !== 3) begin
        n_err++;
        $display("FAIL 5x3_count_gap%0d: got %0d want 3", p, q.size() - b);
      end
      for (int k = 0; k < 3; k++) begin
        if (b + k < q.size()) r = q[b+k];
        else r = '{-1, -1, -1, -1};
        n_cmp++;
        if (r.x !== k + 1 || r.y !== 1 || r.e !== ee[k]) begin
          n_err++;
          $display("FAIL 5x3_res%0d_gap%0d: got (%0d,%0d) e=%0d want (%0d,1) e=%0d",
                   k, p, r.x, r.y, r.e, k + 1, ee[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    @(negedge clk);
    cfg_width = CW'(4);
    cfg_height = CW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1;
      s_pixel = 8'(k);
      @(negedge clk);
    end
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, cfg_err, s_ready, win_valid, m_valid} !== 6'b0 ||
        win_pixels !== 72'h0) begin
      n_err++;
      $display("FAIL reset_mid: ctl=%b win=%h want all zero",
               {busy, done, cfg_err, s_ready, win_valid, m_valid}, win_pixels);
    end
    @(negedge clk);
    reset = 1'b0;
    b = q.size();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (q.size() !== b || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stale: got %0d results busy=%b want 0 results busy=0",
               q.size() - b, busy);
    end
    test_frame_4x4();
  endtask

  task automatic test_start_during_run();
    int   b, e;
    res_t r;
    int   ee[4] = '{5, 6, 9, 10};
    b = q.size();
    e = err_cnt;
    run_frame(4, 4, 1'b0, 1'b1);
    n_cmp++;
    if (err_cnt - e !== 0 || q.size() - b !== 4) begin
      n_err++;
      $display("FAIL start_in_run: got err=%0d n=%0d want err=0 n=4",
               err_cnt - e, q.size() - b);
    end
    for (int k = 0; k < 4; k++) begin
      if (b + k < q.size()) r = q[b+k];
      else r = '{-1, -1, -1, -1};
      n_cmp++;
      if (r.e !== ee[k] || r.x !== 1 + k % 2 || r.y !== 1 + k / 2) begin
        n_err++;
        $display("FAIL start_in_run_res%0d: got (%0d,%0d) e=%0d want (%0d,%0d) e=%0d",
                 k, r.x, r.y, r.e, 1 + k % 2, 1 + k / 2, ee[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_4x4();
    test_cfg_err();
    test_min_frame();
    test_gaps();
    test_reset_mid();
    test_start_during_run();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
